// File: rtl/frame_draw_sequencer.sv
// Per-frame draw sequencer: snapshots object coordinates on tick, then streams
// one pixel per cycle to the framebuffer write port through the clear, pipe 1,
// pipe 2 and bird passes, finishing with a single frame_done pulse.
//
// state | meaning
// IDLE  | waiting for tick; busy low
// CLEAR | full-screen background fill, row-major
// PIPE1 | first pipe column; gap rows consume cycles without writing
// PIPE2 | second pipe column, same as PIPE1
// BIRD  | bird square, clipped to the screen
// DONE  | frame_done pulse, then back to IDLE
module frame_draw_sequencer #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PIPE_W   = 40,
    parameter int GAP_H    = 120,
    parameter int BIRD_SZ  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [10:0] pipe1_x,
    input  logic [10:0] pipe1_y,
    input  logic [10:0] pipe2_x,
    input  logic [10:0] pipe2_y,
    input  logic [10:0] bird_x,
    input  logic [10:0] bird_y,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        color,
    output logic        pixel_write,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, CLEAR, PIPE1, PIPE2, BIRD, DONE} state_t;

    typedef struct packed {
        logic [10:0] p1x;
        logic [10:0] p1y;
        logic [10:0] p2x;
        logic [10:0] p2y;
        logic [10:0] bx;
        logic [10:0] by;
    } snap_t;

    typedef struct packed {
        logic [11:0] x0;
        logic [11:0] x1;
        logic [11:0] y0;
        logic [11:0] y1;
        logic        empty;
    } box_t;

    // 12-bit arithmetic so that coordinate + extent never wraps
    localparam logic [11:0] W_M1  = 12'(SCREEN_W - 1);
    localparam logic [11:0] H_M1  = 12'(SCREEN_H - 1);
    localparam logic [11:0] PW_M1 = 12'(PIPE_W - 1);
    localparam logic [11:0] B_M1  = 12'(BIRD_SZ - 1);
    localparam logic [11:0] GAP_L = 12'(GAP_H);

    state_t      state_q, state_d;
    snap_t       snap_q, snap_d;
    logic [11:0] cx_q, cx_d, cy_q, cy_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        color_q, color_d;
    logic        pw_q, pw_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;

    box_t        cur_b, nxt_b, out_b;
    logic [11:0] gap_top;
    logic        draw_col;

    function automatic logic [11:0] clip(input logic [11:0] a, input logic [11:0] lim);
        return (a > lim) ? lim : a;
    endfunction

    function automatic state_t next_pass(input state_t s);
        case (s)
            CLEAR:   return PIPE1;
            PIPE1:   return PIPE2;
            PIPE2:   return BIRD;
            BIRD:    return DONE;
            default: return IDLE;
        endcase
    endfunction

    // Scan rectangle of a pass; empty when the start lies off-screen
    function automatic box_t box_of(input state_t s, input snap_t sn);
        box_t        b;
        logic [11:0] ox, oy;
        b  = '0;
        ox = '0;
        oy = '0;
        case (s)
            CLEAR: begin
                b.x1 = W_M1;
                b.y1 = H_M1;
            end
            PIPE1, PIPE2: begin
                ox      = (s == PIPE1) ? {1'b0, sn.p1x} : {1'b0, sn.p2x};
                b.x0    = ox;
                b.x1    = clip(ox + PW_M1, W_M1);
                b.y1    = H_M1;
                b.empty = (ox > W_M1);
            end
            BIRD: begin
                ox      = {1'b0, sn.bx};
                oy      = {1'b0, sn.by};
                b.x0    = ox;
                b.y0    = oy;
                b.x1    = clip(ox + B_M1, W_M1);
                b.y1    = clip(oy + B_M1, H_M1);
                b.empty = (ox > W_M1) || (oy > H_M1);
            end
            default: b = '0;
        endcase
        return b;
    endfunction

    // Next scan position/state, then the registered pixel for that position
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        cur_b     = box_of(state_q, snap_q);
        nxt_b     = box_of(next_pass(state_q), snap_q);
        overrun_d = tick && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (tick) begin
                    snap_d  = '{p1x: pipe1_x, p1y: pipe1_y, p2x: pipe2_x,
                                p2y: pipe2_y, bx: bird_x, by: bird_y};
                    state_d = CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            CLEAR, PIPE1, PIPE2, BIRD: begin
                if (cur_b.empty || (cx_q == cur_b.x1 && cy_q == cur_b.y1)) begin
                    state_d = next_pass(state_q);
                    cx_d    = nxt_b.x0;
                    cy_d    = nxt_b.y0;
                end else if (cx_q == cur_b.x1) begin
                    cx_d = cur_b.x0;
                    cy_d = cy_q + 12'd1;
                end else begin
                    cx_d = cx_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        out_b    = box_of(state_d, snap_d);
        gap_top  = (state_d == PIPE1) ? {1'b0, snap_d.p1y} : {1'b0, snap_d.p2y};
        pw_d     = 1'b0;
        draw_col = 1'b1;
        case (state_d)
            CLEAR: begin
                pw_d     = 1'b1;
                draw_col = 1'b0;
            end
            PIPE1, PIPE2: pw_d = !out_b.empty && ((cy_d < gap_top) || (cy_d >= gap_top + GAP_L));
            BIRD:         pw_d = !out_b.empty;
            default:      pw_d = 1'b0;
        endcase

        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        if (pw_d) begin
            x_d     = cx_d[10:0];
            y_d     = cy_d[10:0];
            color_d = draw_col;
        end
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    // State, scan counters, snapshot and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= 1'b0;
            pw_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            pw_q         <= pw_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign color       = color_q;
    assign pixel_write = pw_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Directed bench for frame_draw_sequencer on an 8x4 screen.
module tb_frame_draw_sequencer;

    localparam int W = 8, H = 4, PW = 2, GAP = 2, B = 2;

    logic        clk = 1'b0;
    logic        reset, tick;
    logic [10:0] pipe1_x, pipe1_y, pipe2_x, pipe2_y, bird_x, bird_y;
    logic [10:0] x, y;
    logic        color, pixel_write, busy, frame_done, overrun;

    frame_draw_sequencer #(
        .SCREEN_W(W), .SCREEN_H(H), .PIPE_W(PW), .GAP_H(GAP), .BIRD_SZ(B)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .pipe1_x(pipe1_x), .pipe1_y(pipe1_y), .pipe2_x(pipe2_x), .pipe2_y(pipe2_y),
        .bird_x(bird_x), .bird_y(bird_y),
        .x(x), .y(y), .color(color), .pixel_write(pixel_write),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // per-cycle capture, index = cycle number after the first tick slot (cycle 0)
    bit  obs_pw[0:255], obs_col[0:255], obs_busy[0:255], obs_fd[0:255], obs_ov[0:255];
    int  obs_x[0:255], obs_y[0:255];
    bit  tick_at[0:255];
    int  chg_cyc;
    logic [10:0] chg_bx;

    typedef struct {bit pw; int x; int y; bit col;} pix_t;
    pix_t e[$];
    int mdl_x = 0, mdl_y = 0, mdl_c = 0;

    function automatic int pk(input int px, input int py, input int pc);
        return px * 4096 + py * 2 + pc;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < 256; i++) tick_at[i] = 1'b0;
        chg_cyc = -1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            tick = tick_at[c];
            if (c == chg_cyc) bird_x = chg_bx;
            @(negedge clk);
            obs_pw[c+1]   = pixel_write;
            obs_x[c+1]    = int'(x);
            obs_y[c+1]    = int'(y);
            obs_col[c+1]  = color;
            obs_busy[c+1] = busy;
            obs_fd[c+1]   = frame_done;
            obs_ov[c+1]   = overrun;
        end
        tick = 1'b0;
    endtask

    task automatic add_box(input int x0, input int y0, input int bw, input int bh,
                           input bit is_pipe, input int gy, input bit col);
        bit wr;
        if (x0 >= W || y0 >= H) begin
            e.push_back('{pw: 1'b0, x: 0, y: 0, col: 1'b0});
        end else begin
            for (int yy = y0; yy < y0 + bh && yy < H; yy++)
                for (int xx = x0; xx < x0 + bw && xx < W; xx++) begin
                    wr = is_pipe ? (yy < gy || yy >= gy + GAP) : 1'b1;
                    e.push_back('{pw: wr, x: xx, y: yy, col: col});
                end
        end
    endtask

    task automatic build_model(input int a_x, input int a_y, input int b_x, input int b_y,
                               input int c_x, input int c_y);
        e.delete();
        add_box(0, 0, W, H, 1'b0, 0, 1'b0);
        add_box(a_x, 0, PW, H, 1'b1, a_y, 1'b1);
        add_box(b_x, 0, PW, H, 1'b1, b_y, 1'b1);
        add_box(c_x, c_y, B, B, 1'b0, 0, 1'b1);
    endtask

    task automatic check_frame(input int s);
        int p, c;
        p = e.size();
        check($sformatf("busy_rise@%0d", s + 1), obs_busy[s+1], 1);
        for (int k = 0; k < p; k++) begin
            c = s + 1 + k;
            check($sformatf("pw@%0d", c), obs_pw[c], e[k].pw);
            if (e[k].pw) begin
                mdl_x = e[k].x;
                mdl_y = e[k].y;
                mdl_c = e[k].col;
            end
            check($sformatf("pix@%0d", c), pk(obs_x[c], obs_y[c], obs_col[c]),
                  pk(mdl_x, mdl_y, mdl_c));
        end
        check($sformatf("fd_early@%0d", s + p), obs_fd[s+p], 0);
        check($sformatf("fd@%0d", s + p + 1), obs_fd[s+p+1], 1);
        check($sformatf("pw_done@%0d", s + p + 1), obs_pw[s+p+1], 0);
        check($sformatf("busy_fall@%0d", s + p + 2), obs_busy[s+p+2], 0);
    endtask

    function automatic int count_wr(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) n += int'(obs_pw[c]);
        return n;
    endfunction

    task automatic set_coords(input int a_x, input int a_y, input int b_x, input int b_y,
                              input int c_x, input int c_y);
        pipe1_x = 11'(a_x); pipe1_y = 11'(a_y);
        pipe2_x = 11'(b_x); pipe2_y = 11'(b_y);
        bird_x  = 11'(c_x); bird_y  = 11'(c_y);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        tick  = 1'b0;
        set_coords(0, 0, 0, 0, 0, 0);
        clear_stim();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // idle after reset: every output at its reset value
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check($sformatf("idle@%0d", i),
                  int'({x, y, color, pixel_write, busy, frame_done, overrun}), 0);
        end

        // basic frame
        set_coords(3, 1, 0, 0, 5, 1);
        clear_stim();
        tick_at[0] = 1'b1;
        build_model(3, 1, 0, 0, 5, 1);
        run(55);
        check_frame(0);
        check("clear_wr", count_wr(1, 32), 32);
        check("pipe1_wr", count_wr(33, 40), 4);
        check("pipe1_first", pk(obs_x[33], obs_y[33], obs_col[33]), pk(3, 0, 1));
        check("pipe1_last", pk(obs_x[40], obs_y[40], obs_col[40]), pk(4, 3, 1));
        check("pipe2_wr", count_wr(41, 48), 4);
        check("pipe2_row01", count_wr(41, 44), 0);
        check("bird_wr", count_wr(49, 52), 4);
        check("bird_first", pk(obs_x[49], obs_y[49], obs_col[49]), pk(5, 1, 1));
        check("bird_last", pk(obs_x[52], obs_y[52], obs_col[52]), pk(6, 2, 1));
        check("fd_c53", obs_fd[53], 1);

        // clipping and empty pass
        set_coords(7, 1, 9, 0, 7, 3);
        clear_stim();
        tick_at[0] = 1'b1;
        build_model(7, 1, 9, 0, 7, 3);
        run(41);
        check_frame(0);
        check("clip_p1_wr", count_wr(33, 36), 2);
        check("clip_p1_top", pk(obs_x[33], obs_y[33], obs_col[33]), pk(7, 0, 1));
        check("clip_p2_empty", obs_pw[37], 0);
        check("clip_bird", pk(obs_x[38], obs_y[38], obs_col[38]), pk(7, 3, 1));
        check("clip_bird_wr", obs_pw[38], 1);
        check("clip_fd39", obs_fd[39], 1);

        // overrun: tick in CLEAR and in DONE dropped; tick right after DONE accepted
        set_coords(3, 1, 0, 0, 5, 1);
        clear_stim();
        tick_at[0] = 1'b1;
        tick_at[10] = 1'b1;
        tick_at[53] = 1'b1;
        tick_at[54] = 1'b1;
        build_model(3, 1, 0, 0, 5, 1);
        run(110);
        check_frame(0);
        check_frame(54);
        for (int c = 1; c <= 109; c++)
            check($sformatf("ov@%0d", c), obs_ov[c], (c == 11 || c == 54) ? 1 : 0);

        // snapshot: bird_x changes mid-frame, latched value is drawn
        set_coords(1, 2, 5, 1, 5, 0);
        clear_stim();
        tick_at[0] = 1'b1;
        chg_cyc = 5;
        chg_bx = 11'd2;
        build_model(1, 2, 5, 1, 5, 0);
        run(55);
        check_frame(0);
        check("snap_bird", pk(obs_x[49], obs_y[49], obs_col[49]), pk(5, 0, 1));

        // reset mid-frame
        set_coords(3, 1, 0, 0, 5, 1);
        clear_stim();
        tick_at[0] = 1'b1;
        run(20);
        reset = 1'b1;
        #1;
        check("rst_pw", pixel_write, 0);
        check("rst_busy", busy, 0);
        check("rst_xy", int'({x, y, color}), 0);
        @(negedge clk);
        reset = 1'b0;
        mdl_x = 0; mdl_y = 0; mdl_c = 0;
        clear_stim();
        run(60);
        n = 0;
        for (int c = 1; c <= 60; c++) n += int'(obs_fd[c]) + int'(obs_pw[c]) + int'(obs_busy[c]);
        check("rst_quiet", n, 0);
        clear_stim();
        tick_at[0] = 1'b1;
        build_model(3, 1, 0, 0, 5, 1);
        run(55);
        check_frame(0);
        check("rst_restart", pk(obs_x[1], obs_y[1], obs_col[1]), pk(0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_draw_sequencer.md
# frame_draw_sequencer

Per-frame drawing controller for the Flappy Bird display path. On each game-tick request it snapshots the object coordinates and drives the single framebuffer write port through a fixed sequence of passes: full-screen clear, pipe 1, pipe 2, bird. It emits one pixel per cycle as registered x/y/color/pixel_write outputs. It replaces ad-hoc clear_en/clear_done coordination with one busy/frame_done handshake, and sits between the game-state logic and VGA_framebuffer.

## Interface
Parameters:
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.
- PIPE_W, 40: pipe column width in pixels.
- GAP_H, 120: pipe gap height in pixels; the gap spans rows pipe_y .. pipe_y+GAP_H-1.
- BIRD_SZ, 16: bird square edge length in pixels.

Ports:
- clk, in, 1: system clock (CLOCK_50 domain).
- reset, in, 1: asynchronous, active-high.
- tick, in, 1: frame request, sampled every cycle; only accepted in IDLE.
- pipe1_x, pipe1_y, pipe2_x, pipe2_y, bird_x, bird_y, in, 11 each: top-left object coordinates.
- x, y, out, 11 each: pixel address to the framebuffer.
- color, out, 1: pixel value; 0 = background, 1 = object.
- pixel_write, out, 1: write strobe to the framebuffer.
- busy, out, 1: high whenever state is not IDLE.
- frame_done, out, 1: one-cycle pulse at frame completion.
- overrun, out, 1: one-cycle pulse for each tick that is not accepted.

## Operation
- States: IDLE, CLEAR, PIPE1, PIPE2, BIRD, DONE.
- IDLE:
  - On tick, latch all six coordinates into a snapshot and enter CLEAR.
  - Later input changes have no effect until the next accepted tick.
- CLEAR: scan y 0..SCREEN_H-1 (outer loop), x 0..SCREEN_W-1 (inner loop); color=0, pixel_write=1 on every pixel.
- PIPE1/PIPE2: bounding box x = px .. min(px+PIPE_W-1, SCREEN_W-1), y = 0..SCREEN_H-1, row-major scan.
  - color=1.
  - pixel_write=1 only when y < py or y ≥ py+GAP_H. Inside the gap, pixel_write=0 but the cycle is still consumed.
- BIRD: box x = bx .. min(bx+BIRD_SZ-1, SCREEN_W-1), y = by .. min(by+BIRD_SZ-1, SCREEN_H-1), row-major scan; color=1, pixel_write=1.
- Empty box: if a pass's start x ≥ SCREEN_W, or (BIRD only) start y ≥ SCREEN_H, the pass takes exactly one cycle with pixel_write=0.
- No bubbles between passes: the cycle after a pass's last pixel presents the next pass's first pixel.
- DONE: frame_done=1 for one cycle, pixel_write=0, then IDLE.
- A tick in any state other than IDLE (DONE included) is dropped, and overrun pulses in the cycle after that tick is sampled.
- Arithmetic: box ends are computed at 12 bits so px+PIPE_W and py+GAP_H cannot wrap. Clipping compares against SCREEN_W-1 / SCREEN_H-1.
- When pixel_write=0, x/y/color hold their last values.

## Timing
- Reset values: x=0, y=0, color=0, pixel_write=0, busy=0, frame_done=0, overrun=0; state IDLE; snapshot 0.
- Reset asserted mid-frame aborts immediately. No partial pass completes, and no frame_done is issued.
- Outputs are registered. If tick is sampled at edge N:
  - CLEAR pixel (0,0) is valid in cycle N+1, and busy rises in cycle N+1.
  - Total frame = P drawing cycles, where P = SCREEN_W·SCREEN_H + pass cycles for PIPE1, PIPE2 and BIRD (an empty pass counts as 1).
  - frame_done is high in cycle N+P+1.
  - busy falls in cycle N+P+2, when the state returns to IDLE.
  - A tick sampled in cycle N+P+2 is accepted.
- Pass cycle count = box_width × box_height, or 1 if the box is empty.

## Test plan
All scenarios use SCREEN_W=8, SCREEN_H=4, PIPE_W=2, GAP_H=2, BIRD_SZ=2.
- Reset then idle, no tick: all outputs hold their reset values for 100 cycles; busy stays 0.
- Frame with pipe1=(3,1), pipe2=(0,0), bird=(5,1), tick at cycle 0:
  - 32 clear writes with color 0 on cycles 1–32.
  - PIPE1: 8 cycles; writes at (3,0), (4,0), (3,3), (4,3).
  - PIPE2: 8 cycles; writes only in rows 2–3.
  - BIRD: 4 writes at (5,1), (6,1), (5,2), (6,2).
  - frame_done in cycle 53.
- Clipping with bird=(7,3), pipe1_x=7, pipe2_x=9:
  - BIRD writes only (7,3) in 1 cycle.
  - PIPE1 scans x=7 only (4 cycles).
  - PIPE2 is empty: 1 cycle, pixel_write=0.
- Overrun: tick during CLEAR, and tick in the DONE cycle → overrun pulses once for each, and frame timing is unchanged. A tick one cycle after DONE starts a new frame.
- Snapshot: change bird_x on cycle 5 of a frame → that frame's BIRD pass uses the value latched at the tick.
- Reset at cycle 20 of a frame → pixel_write=0 and busy=0 immediately, no frame_done; the next tick starts a full frame from (0,0).
